// File: rtl/vr194_shift_ctrl.sv
// Command sequencer for one external 74x194-style 4-bit universal shift register.
// Optional rotate support: define VR194_CTRL_ROTATE_EN to enable ROTA/ROTD.
module vr194_shift_ctrl #(
   parameter int unsigned CNT_W = 4
) (
   input  logic             CLK,
   input  logic             CLR_L,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_cnt,
   input  logic [3:0]       cmd_data,
   input  logic             cmd_fill,
   input  logic             QA,
   input  logic             QB,
   input  logic             QC,
   input  logic             QD,
   output logic             S1,
   output logic             S0,
   output logic             LIN,
   output logic             RIN,
   output logic             A,
   output logic             B,
   output logic             C,
   output logic             D,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [3:0]       result
);

   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_SHA  = 3'b010;
   localparam logic [2:0] OP_SHD  = 3'b011;
   localparam logic [2:0] OP_ROTA = 3'b100;
   localparam logic [2:0] OP_ROTD = 3'b101;

`ifdef VR194_CTRL_ROTATE_EN
   localparam bit ROT_EN = 1'b1;
`else
   localparam bit ROT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [2:0]         op_q;
   logic [3:0]         data_q;
   logic               fill_q;
   logic               illegal_q;
   logic               accept;
   logic               op_is_shift;
   logic               op_illegal;

   assign accept      = cmd_valid && cmd_ready;
   assign op_is_shift = (cmd_op == OP_SHA) || (cmd_op == OP_SHD) ||
                        (ROT_EN && ((cmd_op == OP_ROTA) || (cmd_op == OP_ROTD)));
   assign op_illegal  = (cmd_op[2:1] == 2'b11) || (!ROT_EN && (cmd_op[2:1] == 2'b10));

   // State, counter and latched command
   always_ff @(posedge CLK or negedge CLR_L) begin
      if (!CLR_L) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         data_q    <= '0;
         fill_q    <= 1'b0;
         illegal_q <= 1'b0;
         result    <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            cnt_q     <= cmd_cnt;
            op_q      <= cmd_op;
            data_q    <= cmd_data;
            fill_q    <= cmd_fill;
            illegal_q <= op_illegal;
         end else if (state_q == ST_SHIFT && cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
         if (state_q == ST_DONE) begin
            result <= {QA, QB, QC, QD};
         end
      end
   end

   // Next-state decode
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (cmd_op == OP_LOAD)                 state_d = ST_LOAD;
               else if (op_is_shift && cmd_cnt != '0) state_d = ST_SHIFT;
               else                                   state_d = ST_DONE;
            end
         end
         ST_LOAD:  state_d = ST_DONE;
         ST_SHIFT: if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Register drive decoded from state; rotate feeds the far-end Q back in
   always_comb begin
      cmd_ready    = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      err          = 1'b0;
      S1           = 1'b0;
      S0           = 1'b0;
      LIN          = 1'b0;
      RIN          = 1'b0;
      {A, B, C, D} = 4'b0000;
      case (state_q)
         ST_IDLE: cmd_ready = CLR_L;
         ST_LOAD: begin
            busy         = 1'b1;
            S1           = 1'b1;
            S0           = 1'b1;
            {A, B, C, D} = data_q;
         end
         ST_SHIFT: begin
            busy = 1'b1;
            case (op_q)
               OP_SHA: begin
                  S0  = 1'b1;
                  LIN = fill_q;
               end
               OP_SHD: begin
                  S1  = 1'b1;
                  RIN = fill_q;
               end
`ifdef VR194_CTRL_ROTATE_EN
               OP_ROTA: begin
                  S0  = 1'b1;
                  LIN = QD;
               end
               OP_ROTD: begin
                  S1  = 1'b1;
                  RIN = QA;
               end
`endif
               default: ;
            endcase
         end
         ST_DONE: begin
            busy = 1'b1;
            done = 1'b1;
            err  = illegal_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_vr194_shift_ctrl.sv
// Bench for vr194_shift_ctrl: behavioural register + transaction model, per-cycle compare,
// directed literal scenarios then randomized traffic. Honours VR194_CTRL_ROTATE_EN.
module tb_vr194_shift_ctrl;
   localparam int unsigned CNT_W = 4;

`ifdef VR194_CTRL_ROTATE_EN
   localparam bit ROT = 1'b1;
`else
   localparam bit ROT = 1'b0;
`endif

   logic             CLK = 1'b0;
   logic             CLR_L = 1'b0;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [2:0]       cmd_op = '0;
   logic [CNT_W-1:0] cmd_cnt = '0;
   logic [3:0]       cmd_data = '0;
   logic             cmd_fill = 1'b0;
   logic [3:0]       q;
   logic             S1, S0, LIN, RIN, A, B, C, D, busy, done, err;
   logic [3:0]       result;

   int checks = 0;
   int errors = 0;

   vr194_shift_ctrl #(.CNT_W(CNT_W)) dut (
      .CLK(CLK), .CLR_L(CLR_L), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data), .cmd_fill(cmd_fill),
      .QA(q[3]), .QB(q[2]), .QC(q[1]), .QD(q[0]),
      .S1(S1), .S0(S0), .LIN(LIN), .RIN(RIN), .A(A), .B(B), .C(C), .D(D),
      .busy(busy), .done(done), .err(err), .result(result)
   );

   always #5 CLK = ~CLK;

   // External shift register, q = {QA,QB,QC,QD}
   always @(posedge CLK or negedge CLR_L) begin
      if (!CLR_L) q <= 4'b0000;
      else begin
         case ({S1, S0})
            2'b11:   q <= {A, B, C, D};
            2'b01:   q <= {LIN, q[3:1]};
            2'b10:   q <= {q[2:0], RIN};
            default: q <= q;
         endcase
      end
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
      end
   endtask

   function automatic logic [3:0] step(input logic [2:0] op, input logic fill, input logic [3:0] v);
      case (op)
         3'd2:    return {fill, v[3:1]};
         3'd3:    return {v[2:0], fill};
         3'd4:    return {v[0], v[3:1]};
         3'd5:    return {v[2:0], v[3]};
         default: return v;
      endcase
   endfunction

   // Transaction model: one command at a time, phase counts cycles since acceptance
   bit         m_active = 1'b0;
   int         m_phase = 0;
   int         m_lat = 0;
   int         m_cnt = 0;
   logic [2:0] m_op = '0;
   logic [3:0] m_data = '0;
   logic       m_fill = 1'b0;
   logic       m_illegal = 1'b0;
   logic [3:0] m_reg = '0;
   logic [3:0] m_final = '0;
   logic [3:0] m_result = '0;
   logic [3:0] vals [0:16];

   always @(posedge CLK or negedge CLR_L) begin
      if (!CLR_L) begin
         m_active = 1'b0;
         m_reg    = 4'b0000;
         m_result = 4'b0000;
      end else if (m_active) begin
         if (m_phase == m_lat) begin
            m_active = 1'b0;
            m_reg    = m_final;
            m_result = m_final;
         end else m_phase++;
      end else if (cmd_valid) begin
         m_op      = cmd_op;
         m_data    = cmd_data;
         m_fill    = cmd_fill;
         m_cnt     = int'(cmd_cnt);
         m_illegal = (cmd_op >= 3'd6) || (!ROT && (cmd_op == 3'd4 || cmd_op == 3'd5));
         vals[0]   = m_reg;
         for (int i = 0; i < 16; i++) vals[i+1] = step(m_op, m_fill, vals[i]);
         if (m_illegal || m_op == 3'd0) begin
            m_lat = 1; m_final = m_reg;
         end else if (m_op == 3'd1) begin
            m_lat = 2; m_final = m_data;
         end else begin
            m_lat = 1 + m_cnt; m_final = vals[m_cnt];
         end
         m_active = 1'b1;
         m_phase  = 1;
      end
   end

   // Per-cycle comparison against the model
   always @(negedge CLK) begin
      if (CLR_L) begin
         logic       e_done, in_run, e_load, e_shift, e_lin, e_rin;
         logic [1:0] e_s;
         logic [3:0] e_abcd, e_q, cur;
         e_done  = m_active && (m_phase == m_lat);
         in_run  = m_active && !e_done;
         e_load  = in_run && (m_op == 3'd1);
         e_shift = in_run && (m_op >= 3'd2) && (m_op <= 3'd5);
         cur     = m_active ? vals[m_phase-1] : m_reg;
         e_s     = e_load ? 2'b11 : e_shift ? ((m_op == 3'd2 || m_op == 3'd4) ? 2'b01 : 2'b10) : 2'b00;
         e_abcd  = e_load ? m_data : 4'b0000;
         e_lin   = e_shift && ((m_op == 3'd2) ? m_fill : (m_op == 3'd4) ? cur[0] : 1'b0);
         e_rin   = e_shift && ((m_op == 3'd3) ? m_fill : (m_op == 3'd5) ? cur[3] : 1'b0);
         e_q     = e_done ? m_final : cur;
         check("cmd_ready", 8'(cmd_ready), 8'(!m_active));
         check("busy",      8'(busy),      8'(m_active));
         check("done",      8'(done),      8'(e_done));
         check("err",       8'(err),       8'(e_done && m_illegal));
         check("s1s0",      8'({S1, S0}),  8'(e_s));
         check("abcd",      8'({A, B, C, D}), 8'(e_abcd));
         check("lin",       8'(LIN),       8'(e_lin));
         check("rin",       8'(RIN),       8'(e_rin));
         check("result",    8'(result),    8'(m_result));
         check("qreg",      8'(q),         8'(e_q));
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (!cmd_ready && n < 200) begin
         @(posedge CLK); #1;
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout t=%0t actual=busy required=idle", $time);
      end
   endtask

   // Present one command; returns #1 after the accepting edge plus hold-1 further cycles
   task automatic send(input logic [2:0] op, input logic [3:0] cnt, input logic [3:0] data,
                       input logic fill, input int hold);
      wait_idle();
      cmd_op = op; cmd_cnt = cnt; cmd_data = data; cmd_fill = fill; cmd_valid = 1'b1;
      repeat (hold) begin
         @(posedge CLK); #1;
      end
      cmd_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_drive"}, 8'({S1, S0, LIN, RIN, A, B, C, D}), 8'h00);
      check({tag, "_status"}, 8'({cmd_ready, busy, done, err}), 8'h0);
      check({tag, "_result"}, 8'(result), 8'h0);
   endtask

   task automatic cycle();
      @(posedge CLK); #1;
   endtask

   initial begin
      #2;
      check_reset_outputs("por");
      #15 CLR_L = 1'b1;
      #1;
      check("por_ready", 8'({cmd_ready, busy}), 8'b10);

      // LOAD 1010
      send(3'd1, 4'd0, 4'b1010, 1'b0, 1);
      check("load_s", 8'({S1, S0, A, B, C, D}), 8'b111010);
      cycle();
      check("load_done", 8'(done), 8'd1);
      wait_idle();
      check("load_result", 8'(result), 8'h0a);

      // SHA cnt=2 fill=1 from 1010
      send(3'd2, 4'd2, 4'b0000, 1'b1, 1);
      check("sha_c1", 8'({S1, S0, LIN}), 8'b011);
      cycle();
      check("sha_c2", 8'({S1, S0, LIN, q}), 8'b011_1101);
      cycle();
      check("sha_done", 8'({done, q}), 8'b1_1110);
      wait_idle();
      check("sha_result", 8'(result), 8'h0e);

      // ROTD cnt=1 from 1010
      send(3'd1, 4'd0, 4'b1010, 1'b0, 1);
      send(3'd5, 4'd1, 4'b0000, 1'b0, 1);
      if (ROT) begin
         check("rotd_c1", 8'({S1, S0, RIN}), 8'b101);
         wait_idle();
         check("rotd_result", 8'(result), 8'h05);
      end else begin
         check("rotd_off", 8'({done, err, S1, S0}), 8'b1100);
         wait_idle();
         check("rotd_off_result", 8'(result), 8'h0a);
      end

      // SHD cnt=0, NOP, illegal, held valid
      send(3'd1, 4'd0, 4'b0110, 1'b0, 1);
      send(3'd3, 4'd0, 4'b0000, 1'b1, 1);
      check("shd0_done", 8'({done, err, S1, S0}), 8'b1000);
      send(3'd0, 4'd5, 4'b0000, 1'b0, 1);
      check("nop_done", 8'({done, err, S1, S0}), 8'b1000);
      send(3'd6, 4'd3, 4'b1111, 1'b1, 1);
      check("ill_done", 8'({done, err, q}), 8'b11_0110);
      wait_idle();
      check("ill_result", 8'(result), 8'h06);
      send(3'd2, 4'd3, 4'b0000, 1'b0, 3);
      wait_idle();
      check("held_result", 8'(result), 8'h00);

      // Reset in the middle of a long shift
      send(3'd1, 4'd0, 4'b1001, 1'b0, 1);
      send(3'd3, 4'd15, 4'b0000, 1'b1, 1);
      repeat (3) cycle();
      CLR_L = 1'b0;
      #1;
      check_reset_outputs("midrst");
      repeat (2) cycle();
      CLR_L = 1'b1;
      #1;
      check("midrst_rel", 8'({cmd_ready, busy, done}), 8'b100);

      // Randomized traffic with occasional resets
      for (int it = 0; it < 2500; it++) begin
         if ($urandom_range(0, 299) == 0) begin
            CLR_L = 1'b0;
            #1;
            check_reset_outputs("rnd_rst");
            cycle();
            CLR_L = 1'b1;
         end
         cmd_valid = ($urandom_range(0, 2) != 0);
         cmd_op    = 3'($urandom_range(0, 7));
         cmd_cnt   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
         cmd_data  = 4'($urandom);
         cmd_fill  = 1'($urandom);
         cycle();
      end
      cmd_valid = 1'b0;
      repeat (20) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
